mux_4_1_arbiter: RTL and testbench
==================================

MUX_4_1_ARBITER -- requirements
Module: mux_4_1_arbiter

Interface
REQ-001 SHALL provide parameter: MAX_HOLD, 8, maximum consecutive BUSY cycles per grant (legal 2..255).
REQ-002 SHALL provide ports, clock and reset first:
- Clk  input  1  sole clock; all state updates on rising edge.
- Rst  input  1  reset; synchronous, active-high.
- Req  input  4  Req[k]=1: requester k wants the shared 4:1 mux.
- In0, In1, In2, In3  input  1 each  mux data inputs, one per requester.
- Gnt  output  4  one-hot grant, registered; 0000 when idle.
- Sel1, Sel0  output  1 each  registered mux select, {Sel1,Sel0} = owner index.
- Out  output  1  shared mux output.
- Valid  output  1  1 while Out carries granted requester's data.
- Timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Function
REQ-003 SHALL implement a two-state FSM: IDLE, BUSY.
REQ-004 SHALL keep a 2-bit round-robin pointer Ptr (highest priority index) and a hold counter Cnt of ceil(log2(MAX_HOLD)) bits.
REQ-005 In IDLE with Req=0000: SHALL stay in IDLE with Gnt=0000, Valid=0, Sel and Ptr unchanged.
REQ-006 In IDLE with Req!=0000: SHALL pick the first k with Req[k]=1, searching Ptr, Ptr+1, ... mod 4; at the next edge SHALL enter BUSY with Gnt one-hot at k, {Sel1,Sel0}=k, Cnt=0.
REQ-007 Grant latency SHALL be exactly one cycle from the first edge sampling Req in IDLE.
REQ-008 In BUSY: Gnt and Sel SHALL remain constant; Cnt SHALL increment by 1 per cycle.
REQ-009 Release on owner drop: In BUSY with Req[owner]=0 sampled, next edge SHALL enter IDLE, Gnt=0000, Ptr=(owner+1) mod 4, Timeout=0.
REQ-010 Release on timeout: In BUSY with Req[owner]=1 and Cnt=MAX_HOLD-1, next edge SHALL enter IDLE, Gnt=0000, Ptr=(owner+1) mod 4, Timeout=1 for exactly that one cycle.
REQ-011 If owner drop and Cnt=MAX_HOLD-1 coincide, owner drop SHALL win (Timeout=0).
REQ-012 Every release SHALL insert exactly one IDLE cycle with Gnt=0000 before the next grant; no back-to-back grants.
REQ-013 Ptr SHALL wrap 3->0.
REQ-014 Req changes of non-owners during BUSY SHALL be ignored until the next IDLE arbitration.
REQ-015 Out SHALL be combinational: In[{Sel1,Sel0}] when state=BUSY, else 0.
REQ-016 Valid SHALL equal (state==BUSY).
REQ-017 Gnt SHALL never have more than one bit set.
REQ-018 With Req held at 1111, each requester SHALL get one grant of MAX_HOLD cycles per 4*(MAX_HOLD+1) cycles.

Reset
REQ-019 Rst=1 at an edge SHALL force IDLE, Gnt=0000, Sel1=0, Sel0=0, Ptr=0, Cnt=0, Timeout=0, so Valid=0 and Out=0; this SHALL override any in-progress grant.
REQ-020 In the first cycle after Rst deasserts, arbitration SHALL follow REQ-005/REQ-006 with Ptr=0.

Verification
REQ-021 Bench SHALL cover:
- Reset: Rst=1 for 2 cycles, Req=1111 -> Gnt=0000, Sel=00, Valid=0, Out=0, Timeout=0.
- Single requester: Req=0100, In2=1 -> one cycle later Gnt=0100, Sel1=1, Sel0=0, Valid=1, Out=1; toggling In2 toggles Out in the same cycle.
- Fairness/timeout, MAX_HOLD=4: Req=1111 held -> Gnt sequence 0001,0010,0100,1000,0001, each for 4 cycles, each followed by one 0000 cycle with Timeout=1.
- Early release/wrap: requester 3 owns, Req drops to 0011 after 2 BUSY cycles -> one idle cycle, then Gnt=0001 (Ptr wrapped to 0), Timeout=0.
- Coincident release: owner drops Req in the cycle Cnt=MAX_HOLD-1 -> Timeout stays 0; Ptr advances.
- Reset mid-BUSY: Rst=1 while Gnt=0010 -> next edge Gnt=0000, Valid=0; after release, Req=1010 -> Gnt=0010 (Ptr=0 search order).

Source files
------------

// File: rtl/mux_4_1_arbiter.sv
// Round-robin arbiter for four requesters sharing one 4:1 mux. Grants are held
// until the owner drops its request or MAX_HOLD cycles elapse.
module mux_4_1_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] Req,
    input  logic       In0,
    input  logic       In1,
    input  logic       In2,
    input  logic       In3,
    output logic [3:0] Gnt,
    output logic       Sel1,
    output logic       Sel0,
    output logic       Out,
    output logic       Valid,
    output logic       Timeout
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_reg;
    logic [3:0]       gnt_reg;
    logic [1:0]       sel_reg;
    logic [1:0]       ptr_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             timeout_reg;

    logic [3:0]       in_vec;
    logic [3:0]       rot_req;
    logic [1:0]       pick_off;
    logic [1:0]       pick_idx;
    logic             owner_req;

    assign in_vec = {In3, In2, In1, In0};

    // rot_req[i] is the request of the requester i positions after the pointer,
    // so the lowest set bit is the round-robin winner.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            logic [1:0] idx;
            assign idx         = ptr_reg + 2'(gi);
            assign rot_req[gi] = Req[idx];
        end
    endgenerate

    always_comb begin
        pick_off = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot_req[i]) begin
                pick_off = 2'(i);
            end
        end
    end

    assign pick_idx  = ptr_reg + pick_off;
    assign owner_req = Req[sel_reg];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg   <= IDLE;
            gnt_reg     <= 4'b0000;
            sel_reg     <= 2'd0;
            ptr_reg     <= 2'd0;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    timeout_reg <= 1'b0;
                    if (|Req) begin
                        state_reg <= BUSY;
                        gnt_reg   <= 4'b0001 << pick_idx;
                        sel_reg   <= pick_idx;
                        cnt_reg   <= '0;
                    end
                end
                BUSY: begin
                    // Owner drop takes precedence over an expiring hold counter.
                    if (!owner_req) begin
                        state_reg   <= IDLE;
                        gnt_reg     <= 4'b0000;
                        ptr_reg     <= sel_reg + 2'd1;
                        timeout_reg <= 1'b0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg   <= IDLE;
                        gnt_reg     <= 4'b0000;
                        ptr_reg     <= sel_reg + 2'd1;
                        timeout_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    gnt_reg   <= 4'b0000;
                end
            endcase
        end
    end

    assign Gnt     = gnt_reg;
    assign Sel1    = sel_reg[1];
    assign Sel0    = sel_reg[0];
    assign Valid   = (state_reg == BUSY);
    assign Out     = (state_reg == BUSY) ? in_vec[sel_reg] : 1'b0;
    assign Timeout = timeout_reg;

endmodule

// File: tb/tb_mux_4_1_arbiter.sv
// Bench for mux_4_1_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model of ownership, pointer and hold time.
module tb_mux_4_1_arbiter;

    localparam int MAX_HOLD = 4;

    logic       Clk;
    logic       Rst;
    logic [3:0] Req;
    logic       In0, In1, In2, In3;
    logic [3:0] Gnt;
    logic       Sel1, Sel0, Out, Valid, Timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: who owns the mux, how long it has held it, next priority.
    int   m_owner   = -1;
    int   m_ptr     = 0;
    int   m_sel     = 0;
    int   m_held    = 0;
    logic m_timeout = 1'b0;

    mux_4_1_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req),
        .In0(In0), .In1(In1), .In2(In2), .In3(In3),
        .Gnt(Gnt), .Sel1(Sel1), .Sel0(Sel0),
        .Out(Out), .Valid(Valid), .Timeout(Timeout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic void model_step();
        logic found;
        if (Rst) begin
            m_owner = -1; m_ptr = 0; m_sel = 0; m_held = 0; m_timeout = 1'b0;
        end else if (m_owner < 0) begin
            m_timeout = 1'b0;
            found = 1'b0;
            for (int j = 0; j < 4; j++) begin
                if (!found && Req[(m_ptr + j) % 4]) begin
                    found   = 1'b1;
                    m_owner = (m_ptr + j) % 4;
                    m_sel   = m_owner;
                    m_held  = 1;
                end
            end
        end else if (!Req[m_owner]) begin
            m_ptr = (m_owner + 1) % 4; m_owner = -1; m_timeout = 1'b0;
        end else if (m_held == MAX_HOLD) begin
            m_ptr = (m_owner + 1) % 4; m_owner = -1; m_timeout = 1'b1;
        end else begin
            m_held++;
        end
    endfunction

    // Expected {Gnt, Sel1, Sel0, Valid, Out, Timeout} given the current data inputs.
    function automatic logic [8:0] exp_vec();
        logic [3:0] ins;
        logic [3:0] g;
        logic [1:0] s;
        logic       o;
        ins = {In3, In2, In1, In0};
        g   = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        o   = (m_owner < 0) ? 1'b0 : ins[m_owner];
        s   = 2'(m_sel);
        return {g, s, (m_owner >= 0), o, m_timeout};
    endfunction

    task automatic tick();
        @(posedge Clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] got;
        Rst = 1'b1; Req = 4'b1111; {In3, In2, In1, In0} = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            got = {Gnt, Sel1, Sel0, Valid, Out, Timeout};
            n_checks++;
            if (got !== 9'b0) begin
                n_fail++;
                $display("FAIL reset cyc %0d: got %b required %b", cyc, got, 9'b0);
            end
        end
    endtask

    task automatic test_single();
        Rst = 1'b0; Req = 4'b0100; {In3, In2, In1, In0} = 4'b0100;
        tick();
        n_checks++;
        if ({Gnt, Sel1, Sel0, Valid, Out} !== {4'b0100, 2'b10, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL single_grant cyc %0d: got %b required %b", cyc,
                     {Gnt, Sel1, Sel0, Valid, Out}, {4'b0100, 2'b10, 1'b1, 1'b1});
        end
        In2 = 1'b0; #1;
        n_checks++;
        if (Out !== 1'b0) begin
            n_fail++;
            $display("FAIL single_toggle_lo cyc %0d: Out %b required 0", cyc, Out);
        end
        In2 = 1'b1; #1;
        n_checks++;
        if (Out !== 1'b1) begin
            n_fail++;
            $display("FAIL single_toggle_hi cyc %0d: Out %b required 1", cyc, Out);
        end
        Req = 4'b0000;
        tick();
        n_checks++;
        if ({Gnt, Valid, Out, Timeout} !== 7'b0) begin
            n_fail++;
            $display("FAIL single_release cyc %0d: got %b required 0000000", cyc,
                     {Gnt, Valid, Out, Timeout});
        end
    endtask

    task automatic test_fairness();
        int gcount [4];
        int tcount;
        logic [8:0] got, exp;
        for (int k = 0; k < 4; k++) gcount[k] = 0;
        tcount = 0;
        Rst = 1'b1; Req = 4'b1111;
        tick();
        Rst = 1'b0;
        for (int i = 0; i < 4 * (MAX_HOLD + 1); i++) begin
            {In3, In2, In1, In0} = 4'($urandom_range(0, 15));
            tick();
            got = {Gnt, Sel1, Sel0, Valid, Out, Timeout};
            exp = exp_vec();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL fairness cyc %0d: got %b required %b", cyc, got, exp);
            end
            for (int k = 0; k < 4; k++) if (Gnt[k]) gcount[k]++;
            if (Timeout) tcount++;
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (gcount[k] != MAX_HOLD) begin
                n_fail++;
                $display("FAIL fairness_share req%0d: %0d cycles required %0d", k, gcount[k], MAX_HOLD);
            end
        end
        n_checks++;
        if (tcount != 4) begin
            n_fail++;
            $display("FAIL fairness_timeouts: %0d pulses required 4", tcount);
        end
        tick();
        n_checks++;
        if (Gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL fairness_wrap cyc %0d: Gnt %b required 0001", cyc, Gnt);
        end
    endtask

    task automatic test_early_wrap();
        Rst = 1'b1; tick();
        Rst = 1'b0; Req = 4'b1000;
        tick();
        tick();
        n_checks++;
        if (Gnt !== 4'b1000) begin
            n_fail++;
            $display("FAIL wrap_owner cyc %0d: Gnt %b required 1000", cyc, Gnt);
        end
        Req = 4'b0011;
        tick();
        n_checks++;
        if ({Gnt, Valid, Timeout} !== 6'b0) begin
            n_fail++;
            $display("FAIL wrap_idle cyc %0d: got %b required 000000", cyc, {Gnt, Valid, Timeout});
        end
        tick();
        n_checks++;
        if ({Gnt, Timeout} !== 5'b00010) begin
            n_fail++;
            $display("FAIL wrap_regrant cyc %0d: got %b required 00010", cyc, {Gnt, Timeout});
        end
    endtask

    task automatic test_coincident();
        Rst = 1'b1; tick();
        Rst = 1'b0; Req = 4'b0001;
        for (int i = 0; i < MAX_HOLD; i++) tick();
        Req = 4'b0010;
        tick();
        n_checks++;
        if ({Gnt, Valid, Timeout} !== 6'b0) begin
            n_fail++;
            $display("FAIL coincident_release cyc %0d: got %b required 000000", cyc, {Gnt, Valid, Timeout});
        end
        tick();
        n_checks++;
        if (Gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL coincident_ptr cyc %0d: Gnt %b required 0010", cyc, Gnt);
        end
    endtask

    task automatic test_reset_mid_busy();
        Rst = 1'b1;
        tick();
        n_checks++;
        if ({Gnt, Valid, Out} !== 6'b0) begin
            n_fail++;
            $display("FAIL midreset cyc %0d: got %b required 000000", cyc, {Gnt, Valid, Out});
        end
        Rst = 1'b0; Req = 4'b1010;
        tick();
        n_checks++;
        if (Gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL midreset_regrant cyc %0d: Gnt %b required 0010", cyc, Gnt);
        end
    endtask

    task automatic test_random();
        logic [8:0] got, exp;
        Rst = 1'b1; tick();
        Rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) Req = 4'($urandom_range(0, 15));
            Rst = ($urandom_range(0, 39) == 0);
            {In3, In2, In1, In0} = 4'($urandom_range(0, 15));
            tick();
            got = {Gnt, Sel1, Sel0, Valid, Out, Timeout};
            exp = exp_vec();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random cyc %0d: Req %b got %b required %b", cyc, Req, got, exp);
            end
            n_checks++;
            if ($countones(Gnt) > 1) begin
                n_fail++;
                $display("FAIL random_onehot cyc %0d: Gnt %b required at most one bit", cyc, Gnt);
            end
        end
        Rst = 1'b0;
    endtask

    initial begin
        Rst = 1'b1; Req = 4'b0000; {In3, In2, In1, In0} = 4'b0000;
        test_reset();
        test_single();
        test_fairness();
        test_early_wrap();
        test_coincident();
        test_reset_mid_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
